qam_sym_gen: RTL and testbench

Parametrised test-data source for the QAM transmitter chain. Emits one BITS_PER_SYM-bit symbol every SYM_PERIOD clocks to the mapper, with a valid/ready handshake. Supports three data modes: rotating fixed pattern, PRBS15 and counting. It also provides the legacy one-cycle data_change strobe. It is the successor to the single-bit, fixed-period pattern generator.

---
 rtl/qam_gen_pkg.sv | 18 +
 rtl/qam_sym_gen_if.sv | 12 +
 rtl/lfsr_prbs15_step.sv | 25 ++
 rtl/qam_sym_gen.sv | 110 +++++++++++
 tb/tb_qam_sym_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/qam_gen_pkg.sv
// Shared constants for the QAM test-symbol source: mode encodings, PRBS15
// seed and taps, and the default fixed pattern.
package qam_gen_pkg;

    typedef enum logic [1:0] {
        MODE_PATTERN = 2'd0,
        MODE_PRBS    = 2'd1,
        MODE_COUNT   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam logic [14:0] PRBS_SEED   = 15'h7FFF;
    localparam int          PRBS_TAP_HI = 14;
    localparam int          PRBS_TAP_LO = 13;

    localparam logic [27:0] PATTERN_DEFAULT = 28'h6CC1555;

endpackage

// File: rtl/qam_sym_gen_if.sv
// Symbol handshake between the test-data source and the QAM mapper.
interface qam_sym_gen_if #(
    parameter int BITS_PER_SYM = 4
);
    logic [BITS_PER_SYM-1:0] sym_data;
    logic                    sym_valid;
    logic                    sym_ready;
    logic                    data_change;

    modport master (output sym_data, output sym_valid, output data_change, input sym_ready);
    modport slave  (input sym_data, input sym_valid, input data_change, output sym_ready);
endinterface

// File: rtl/lfsr_prbs15_step.sv
// PRBS15 (x^15+x^14+1) Fibonacci LFSR advanced STEPS times in one cycle;
// the first bit shifted out lands in the MSB of bits.
module lfsr_prbs15_step
    import qam_gen_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  logic [14:0]      state,
    output logic [14:0]      next_state,
    output logic [STEPS-1:0] bits
);

    logic [14:0] s;

    always_comb begin
        s    = state;
        bits = '0;
        for (int i = 0; i < STEPS; i++) begin
            bits[STEPS-1-i] = s[PRBS_TAP_HI];
            s = {s[13:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
        end
        next_state = s;
    end

endmodule

// File: rtl/qam_sym_gen.sv
// Test-symbol source: one symbol per SYM_PERIOD enabled clocks from a rotating
// pattern, PRBS15 or a counter, delivered over a valid/ready handshake.
module qam_sym_gen
    import qam_gen_pkg::*;
#(
    parameter int                   BITS_PER_SYM = 4,
    parameter int                   SYM_PERIOD   = 8,
    parameter int                   PATTERN_W    = 28,
    parameter logic [PATTERN_W-1:0] PATTERN      = PATTERN_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic                 clear_overrun,
    output logic                 overrun,
    qam_sym_gen_if.master        sym
);

    localparam int CNT_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_PERIOD - 1);

    logic [CNT_W-1:0]        cnt;
    logic [PATTERN_W-1:0]    pattern;
    logic [PATTERN_W-1:0]    pattern_rot;
    logic [14:0]             lfsr;
    logic [14:0]             lfsr_src;
    logic [14:0]             lfsr_next;
    logic [BITS_PER_SYM-1:0] prbs_bits;
    logic [BITS_PER_SYM-1:0] count;
    logic [BITS_PER_SYM-1:0] next_sym;
    logic [BITS_PER_SYM-1:0] sym_data;
    logic                    sym_valid;
    logic                    data_change;
    logic                    tick;
    logic                    load;
    logic                    stall;

    assign tick  = enable && (cnt == CNT_LAST);
    assign load  = tick && (!sym_valid || sym_sready());
    assign stall = tick && sym_valid && !sym_sready();

    function automatic logic sym_sready();
        return sym.sym_ready;
    endfunction

    // Circular rotate so symbols straddle the wrap when widths don't divide.
    assign pattern_rot = {pattern[PATTERN_W-BITS_PER_SYM-1:0], pattern[PATTERN_W-1 -: BITS_PER_SYM]};

    // An all-zero LFSR would lock up; treat it as the seed instead.
    assign lfsr_src = (lfsr == '0) ? PRBS_SEED : lfsr;

    lfsr_prbs15_step #(
        .STEPS (BITS_PER_SYM)
    ) u_prbs (
        .state      (lfsr_src),
        .next_state (lfsr_next),
        .bits       (prbs_bits)
    );

    always_comb begin
        case (mode_e'(mode))
            MODE_PRBS:  next_sym = prbs_bits;
            MODE_COUNT: next_sym = count;
            default:    next_sym = pattern[PATTERN_W-1 -: BITS_PER_SYM];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            sym_data    <= '0;
            sym_valid   <= 1'b0;
            data_change <= 1'b0;
            overrun     <= 1'b0;
            pattern     <= PATTERN;
            lfsr        <= PRBS_SEED;
            count       <= '0;
        end else begin
            data_change <= load;
            if (enable) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end

            if (load) begin
                sym_data  <= next_sym;
                sym_valid <= 1'b1;
                case (mode_e'(mode))
                    MODE_PRBS:  lfsr    <= lfsr_next;
                    MODE_COUNT: count   <= count + 1'b1;
                    default:    pattern <= pattern_rot;
                endcase
            end else if (sym_valid && sym.sym_ready && !tick) begin
                sym_valid <= 1'b0;
            end

            // A stall on the same edge outranks a clear request.
            if (stall) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign sym.sym_data    = sym_data;
    assign sym.sym_valid   = sym_valid;
    assign sym.data_change = data_change;

endmodule

// File: tb/tb_qam_sym_gen.sv
// Directed bench for qam_sym_gen with a 4-bit and a 2-bit symbol instance.
module tb_qam_sym_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en4 = 1'b1, en2 = 1'b1;
    logic [1:0] mode4 = 2'd0, mode2 = 2'd0;
    logic       clr4 = 1'b0, clr2 = 1'b0;
    logic       ovr4, ovr2;

    int n_checks = 0;
    int n_fails  = 0;

    qam_sym_gen_if #(.BITS_PER_SYM(4)) bus4 ();
    qam_sym_gen_if #(.BITS_PER_SYM(2)) bus2 ();

    qam_sym_gen #(.BITS_PER_SYM(4)) u4 (
        .clock         (clk),
        .reset         (rst),
        .enable        (en4),
        .mode          (mode4),
        .clear_overrun (clr4),
        .overrun       (ovr4),
        .sym           (bus4)
    );

    qam_sym_gen #(.BITS_PER_SYM(2)) u2 (
        .clock         (clk),
        .reset         (rst),
        .enable        (en2),
        .mode          (mode2),
        .clear_overrun (clr2),
        .overrun       (ovr2),
        .sym           (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    int pat4[8]  = '{'h6, 'hC, 'hC, 'h1, 'h5, 'h5, 'h5, 'h6};
    int prbs4[4] = '{'hF, 'hF, 'hF, 'hE};
    int prbs2[8] = '{3, 3, 3, 3, 3, 3, 3, 2};

    initial begin
        bus4.sym_ready = 1'b1;
        bus2.sym_ready = 1'b1;

        // Reset state
        step(2);
        check("rst_data", int'(bus4.sym_data), 0);
        check("rst_valid", int'(bus4.sym_valid), 0);
        check("rst_dc", int'(bus4.data_change), 0);
        check("rst_ovr", int'(ovr4), 0);

        // Fixed pattern, always ready
        rst = 1'b0;
        step(7);
        check("pat_early_valid", int'(bus4.sym_valid), 0);
        step(1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pat_data%0d", i), int'(bus4.sym_data), pat4[i]);
            check($sformatf("pat_dc%0d", i), int'(bus4.data_change), 1);
            check($sformatf("pat_valid%0d", i), int'(bus4.sym_valid), 1);
            step(1);
            check($sformatf("pat_dc_off%0d", i), int'(bus4.data_change), 0);
            check($sformatf("pat_hold%0d", i), int'(bus4.sym_data), pat4[i]);
            step(7);
        end

        // PRBS15 on both widths
        mode4 = 2'd1;
        mode2 = 2'd1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(8);
            if (i < 4) check($sformatf("prbs4_%0d", i), int'(bus4.sym_data), prbs4[i]);
            check($sformatf("prbs2_%0d", i), int'(bus2.sym_data), prbs2[i]);
        end

        // Counting with wrap, then switch to pattern mid-slot
        mode2 = 2'd2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(8);
            check($sformatf("cnt2_%0d", i), int'(bus2.sym_data), i % 4);
        end
        step(3);
        mode2 = 2'd0;
        step(5);
        check("cnt2_to_pat", int'(bus2.sym_data), 1);
        check("cnt2_to_pat_dc", int'(bus2.data_change), 1);

        // Backpressure, overrun and clear
        mode4 = 2'd0;
        bus4.sym_ready = 1'b0;
        do_reset();
        step(8);
        check("stall_first", int'(bus4.sym_data), 'h6);
        step(8);
        check("stall1_data", int'(bus4.sym_data), 'h6);
        check("stall1_dc", int'(bus4.data_change), 0);
        check("stall1_ovr", int'(ovr4), 1);
        check("stall1_valid", int'(bus4.sym_valid), 1);
        step(7);
        clr4 = 1'b1;
        step(1);
        clr4 = 1'b0;
        check("stall2_ovr_wins", int'(ovr4), 1);
        check("stall2_data", int'(bus4.sym_data), 'h6);
        check("stall2_dc", int'(bus4.data_change), 0);
        bus4.sym_ready = 1'b1;
        step(8);
        check("resume_data", int'(bus4.sym_data), 'hC);
        check("resume_dc", int'(bus4.data_change), 1);
        clr4 = 1'b1;
        step(1);
        clr4 = 1'b0;
        check("ovr_cleared", int'(ovr4), 0);

        // Enable freeze mid-slot
        do_reset();
        step(3);
        en4 = 1'b0;
        step(20);
        check("freeze_valid", int'(bus4.sym_valid), 0);
        check("freeze_dc", int'(bus4.data_change), 0);
        en4 = 1'b1;
        step(4);
        check("freeze_early", int'(bus4.sym_valid), 0);
        step(1);
        check("freeze_data", int'(bus4.sym_data), 'h6);
        check("freeze_dc_load", int'(bus4.data_change), 1);

        // Asynchronous reset between edges
        bus4.sym_ready = 1'b0;
        do_reset();
        step(8);
        check("pre_async_valid", int'(bus4.sym_valid), 1);
        step(3);
        #2;
        rst = 1'b1;
        #1;
        check("async_data", int'(bus4.sym_data), 0);
        check("async_valid", int'(bus4.sym_valid), 0);
        check("async_ovr", int'(ovr4), 0);
        step(1);
        rst = 1'b0;
        bus4.sym_ready = 1'b1;
        step(7);
        check("restart_early", int'(bus4.sym_valid), 0);
        step(1);
        check("restart_data", int'(bus4.sym_data), 'h6);
        check("restart_dc", int'(bus4.data_change), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
